// File: rtl/dds_pkg.sv
// Shared AD9850 serial-load definitions: receiver states and frame layout.
package dds_pkg;

  typedef enum logic [1:0] {
    PARALLEL = 2'd0,
    ARMED    = 2'd1,
    SERIAL   = 2'd2
  } rx_state_e;

  localparam int unsigned FRAME_BITS     = 40;
  localparam int unsigned TW_BITS        = 32;
  localparam int unsigned CTRL_PHASE_LSB = 35;
  localparam int unsigned CTRL_PD_BIT    = 34;
  localparam int unsigned PHASE_BITS     = FRAME_BITS - CTRL_PHASE_LSB;
  localparam int unsigned REF_CLK_HZ     = 125000000;

  // Bit counter saturates one past a full frame so overruns stay visible.
  localparam int unsigned BIT_CNT_MAX    = FRAME_BITS + 1;
  localparam int unsigned BIT_CNT_W      = $clog2(BIT_CNT_MAX + 1);

endpackage

// File: rtl/dds_pin_sync.sv
// Synchroniser plus rise-edge detector for one DDS control pin.
// RISE_OUT selects the registered rise event; otherwise q is the synchronised
// level delayed to line up with the rise events of the sibling pins.
module dds_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RISE_OUT    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Metastability chain followed by the single edge-history flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  if (RISE_OUT) begin : g_rise
    logic rise_q;

    // Registered single-cycle rise event.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rise_q <= 1'b0;
      end else begin
        rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
      end
    end

    assign q = rise_q;
  end else begin : g_level
    assign q = hist_q;
  end

endmodule

// File: rtl/ad9850_serial_rx.sv
// AD9850 3-wire serial-load receiver: tracks serial-mode entry, deserialises
// 40-bit LSB-first frames and presents the committed tuning/control fields.
module ad9850_serial_rx
  import dds_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOAD_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dds_wclk,
  input  logic                  dds_fqud,
  input  logic                  dds_data,
  input  logic                  dds_reset,
  output logic [TW_BITS-1:0]    tuning_word,
  output logic [PHASE_BITS-1:0] phase,
  output logic                  power_down,
  output logic                  serial_mode,
  output logic                  word_valid,
  output logic                  frame_error,
  output logic                  ctrl_error,
  output logic [LOAD_CNT_W-1:0] load_count
);

  logic wclk_rise;
  logic fqud_rise;
  logic data_lvl;
  logic dreset_lvl;

  dds_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE_OUT(1'b1)) u_sync_wclk (
    .clk(clk), .reset(reset), .pin(dds_wclk), .q(wclk_rise)
  );

  dds_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE_OUT(1'b1)) u_sync_fqud (
    .clk(clk), .reset(reset), .pin(dds_fqud), .q(fqud_rise)
  );

  dds_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE_OUT(1'b0)) u_sync_data (
    .clk(clk), .reset(reset), .pin(dds_data), .q(data_lvl)
  );

  dds_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE_OUT(1'b0)) u_sync_dreset (
    .clk(clk), .reset(reset), .pin(dds_reset), .q(dreset_lvl)
  );

  rx_state_e              state_q, state_d;
  logic [FRAME_BITS-1:0]  sr_q, sr_d, sr_n;
  logic [BIT_CNT_W-1:0]   cnt_q, cnt_d, cnt_n;
  logic [TW_BITS-1:0]     tw_d;
  logic [PHASE_BITS-1:0]  phase_d;
  logic                   pd_d;
  logic                   serial_d;
  logic                   wv_d;
  logic                   fe_d;
  logic                   ce_d;
  logic [LOAD_CNT_W-1:0]  load_d;

  // State, shift register, counter and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= PARALLEL;
      sr_q        <= '0;
      cnt_q       <= '0;
      tuning_word <= '0;
      phase       <= '0;
      power_down  <= 1'b0;
      serial_mode <= 1'b0;
      word_valid  <= 1'b0;
      frame_error <= 1'b0;
      ctrl_error  <= 1'b0;
      load_count  <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      tuning_word <= tw_d;
      phase       <= phase_d;
      power_down  <= pd_d;
      serial_mode <= serial_d;
      word_valid  <= wv_d;
      frame_error <= fe_d;
      ctrl_error  <= ce_d;
      load_count  <= load_d;
    end
  end

  // Mode tracking, shifting and commit decisions; shift is applied before
  // the commit check so a coincident W_CLK/FQ_UD pair sees the new bit.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sr_n    = sr_q;
    cnt_n   = cnt_q;
    tw_d    = tuning_word;
    phase_d = phase;
    pd_d    = power_down;
    wv_d    = 1'b0;
    fe_d    = 1'b0;
    ce_d    = 1'b0;
    load_d  = load_count;

    if (dreset_lvl) begin
      state_d = PARALLEL;
      sr_d    = '0;
      cnt_d   = '0;
      tw_d    = '0;
      phase_d = '0;
      pd_d    = 1'b0;
    end else begin
      unique case (state_q)
        PARALLEL: begin
          if (wclk_rise) begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          if (fqud_rise) begin
            state_d = SERIAL;
            sr_d    = '0;
            cnt_d   = '0;
          end
        end
        SERIAL: begin
          if (wclk_rise) begin
            sr_n  = {data_lvl, sr_q[FRAME_BITS-1:1]};
            cnt_n = (cnt_q == BIT_CNT_W'(BIT_CNT_MAX)) ? cnt_q
                                                       : cnt_q + BIT_CNT_W'(1);
          end
          sr_d  = sr_n;
          cnt_d = cnt_n;
          if (fqud_rise) begin
            if (cnt_n == BIT_CNT_W'(FRAME_BITS)) begin
              tw_d    = sr_n[TW_BITS-1:0];
              pd_d    = sr_n[CTRL_PD_BIT];
              phase_d = sr_n[FRAME_BITS-1:CTRL_PHASE_LSB];
              wv_d    = 1'b1;
              load_d  = load_count + LOAD_CNT_W'(1);
              ce_d    = |sr_n[CTRL_PD_BIT-1:TW_BITS];
            end else if (cnt_n > BIT_CNT_W'(1)) begin
              fe_d = 1'b1;
            end
            sr_d  = '0;
            cnt_d = '0;
          end
        end
        default: begin
          state_d = PARALLEL;
        end
      endcase
    end

    serial_d = (state_d == SERIAL);
  end

endmodule
